nibble_sram_ctrl: RTL
=====================

Name: nibble_sram_ctrl

Overview:
Parametrised successor to the team's pin-limited shared-bus SRAM tile.
- Memory is loaded and read through a narrow nibble port using a small command set.
- Adds generic data width, depth and nibble width, and a multi-nibble address load.
- Adds auto-incrementing burst write and read with address wrap.
- Adds read-valid and write-done strobes, plus asynchronous reset of all control state.
- Sits behind the tile's io_in/io_out pin wrapper, which maps pins to the ports below.

Parameters:
DW, 8, data word width in bits; must be a multiple of NW.
NW, 4, nibble (input bus) width in bits.
DEPTH, 16, number of words; must be a power of two.
AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command strobe; one command per cycle when high.
cmd  input  2  00 SET_ADDR, 01 WRITE_NIB, 10 READ, 11 CLEAR.
nib  input  NW  nibble payload for SET_ADDR and WRITE_NIB; ignored otherwise.
oe  input  1  output enable; dout forced to 0 when low (combinational).
dout  output  DW  read data register, gated by oe.
rd_valid  output  1  one-cycle pulse: dout updated by READ.
wr_done  output  1  one-cycle pulse: full word committed to memory.
nib_cnt  output  $clog2(DW/NW)+1  nibbles currently buffered toward the next word (debug/status).

Behaviour:
- Reset (async assert, sync-release use is the wrapper's job) clears addr, abuf, dbuf, nib_cnt, dout, rd_valid and wr_done to 0. Memory contents are NOT reset.
- cmd_valid low: all state holds; rd_valid and wr_done are 0 next cycle.
- Pulses: rd_valid and wr_done are registered and high exactly one cycle after the triggering edge.
- SET_ADDR: abuf (width AB = NW*ceil(AW/NW)) <= {abuf[AB-NW-1:0], nib}, so nibbles are loaded MSB-first.
  - For AB==NW, abuf <= nib.
  - Current address addr = abuf[AW-1:0].
  - Does not touch dbuf or nib_cnt.
- WRITE_NIB: dbuf <= {nib, dbuf[DW-1:NW]}, so nibbles are loaded LSB-first, and nib_cnt increments.
  - On the nibble that makes nib_cnt reach DW/NW, the same edge writes mem[addr] <= {nib, dbuf[DW-1:NW]}.
  - On that edge: nib_cnt <= 0, abuf low AW bits <= addr+1 (wraps DEPTH-1 -> 0, upper abuf bits cleared), wr_done <= 1.
- READ: dout <= mem[addr] and rd_valid <= 1 next cycle; addr increments with wrap.
  - A READ while nib_cnt != 0 leaves the partial dbuf/nib_cnt intact.
- CLEAR: nib_cnt <= 0 and dbuf <= 0; addr, dout and memory are untouched.
- Read-after-write: a READ issued the cycle after the completing WRITE_NIB returns the newly written word when addr is set back.
  - No same-cycle hazard exists, because there is one command per cycle.
- Latency: READ to data visible on dout = 1 cycle. Completing WRITE_NIB to memory update = 1 cycle.
- Reset mid-burst: partial word discarded, addr = 0; previously committed words are retained.
- Illegal parameter combinations (DW%NW != 0, DEPTH not a power of two) are rejected by an elaboration-time check.

Decomposition:
- Shared package nibble_sram_pkg holds:
  - command encodings CMD_SET_ADDR, CMD_WRITE_NIB, CMD_READ, CMD_CLEAR;
  - a localparam function for AB/nibbles-per-word.
- One natural sub-module: nibble_sram_mem, a DEPTH x DW register array with one write port and one registered read port, no reset.
- The command decode and counters stay in the top level.

Test Plan (DW=8, NW=4, DEPTH=16, oe=1 unless stated):
1. Reset then idle: assert reset mid-cycle -> dout=0, nib_cnt=0, rd_valid=0, wr_done=0 immediately, without waiting for a clock edge.
2. Single write/read: SET_ADDR 3; WRITE_NIB 5, WRITE_NIB A -> wr_done pulse, mem[3]=8'hA5; SET_ADDR 3; READ -> next cycle dout=8'hA5, rd_valid=1.
3. Burst wrap: SET_ADDR F; write words 11, 22 (4 nibbles) -> mem[F]=11, mem[0]=22; SET_ADDR F; READ, READ -> dout 11 then 22.
4. CLEAR mid-word: SET_ADDR 2; WRITE_NIB 7; CLEAR; WRITE_NIB 1, WRITE_NIB 2 -> mem[2]=8'h21, no stray 7, nib_cnt back to 0.
5. oe gating and hold: after READ returning 8'hA5, drop oe -> dout=0; raise oe -> 8'hA5; cmd_valid low for 5 cycles -> no pulses, state unchanged.
6. Reset mid-burst: WRITE_NIB C, then reset, then SET_ADDR 3, READ -> nib_cnt=0, dout=8'hA5 (memory retained from scenario 2).

Source files
------------

// File: rtl/nibble_sram_pkg.sv
// Purpose : shared command encodings and width helpers for the nibble SRAM controller.
// Contents: cmd_e command enum, abuf_width() and nibs_per_word() elaboration helpers.
package nibble_sram_pkg;

   typedef enum logic [1:0] {
      CMD_SET_ADDR  = 2'b00,
      CMD_WRITE_NIB = 2'b01,
      CMD_READ      = 2'b10,
      CMD_CLEAR     = 2'b11
   } cmd_e;

   // Address buffer width: address bits rounded up to a whole number of nibbles.
   function automatic int unsigned abuf_width(input int unsigned aw, input int unsigned nw);
      return nw * ((aw + nw - 1) / nw);
   endfunction

   function automatic int unsigned nibs_per_word(input int unsigned dw, input int unsigned nw);
      return dw / nw;
   endfunction

endpackage

// File: rtl/nibble_sram_mem.sv
// Purpose : DEPTH x DW register array, one write port, one registered read port.
// Ports   : clk, reset (async, clears only the read data register),
//           we/waddr/wdata (write on rising edge), re/raddr (load rdata on rising edge),
//           rdata (registered read data, holds while re is low).
module nibble_sram_mem #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_d;
   logic [DW-1:0] rdata_q;

   // Storage array keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/nibble_sram_ctrl.sv
// Purpose : pin-limited SRAM tile controller; words are loaded and read through a
//           narrow nibble port with auto-incrementing, wrapping address.
// Ports   : clk, reset (async active-high), cmd_valid/cmd/nib (command port),
//           oe (combinational output enable), dout (read data gated by oe),
//           rd_valid (READ data pulse), wr_done (word commit pulse),
//           nib_cnt (nibbles buffered toward the next word).
module nibble_sram_ctrl
   import nibble_sram_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned NW    = 4,
   parameter int unsigned DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   input  logic [1:0]            cmd,
   input  logic [NW-1:0]         nib,
   input  logic                  oe,
   output logic [DW-1:0]         dout,
   output logic                  rd_valid,
   output logic                  wr_done,
   output logic [$clog2(DW/NW):0] nib_cnt
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned NPW = nibs_per_word(DW, NW);
   localparam int unsigned AB  = abuf_width(AW, NW);
   localparam int unsigned CW  = $clog2(NPW) + 1;

   // Reject unusable parameter sets at elaboration.
   if ((DW % NW) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
      $error("nibble_sram_ctrl: DW must be a multiple of NW and DEPTH a power of two >= 2");
   end

   logic [AB-1:0] abuf_q, abuf_d;
   logic [DW-1:0] dbuf_q, dbuf_d;
   logic [CW-1:0] nib_cnt_q, nib_cnt_d;
   logic          rd_valid_q, rd_valid_d;
   logic          wr_done_q, wr_done_d;

   logic [AB-1:0] abuf_shift_c;
   logic [DW-1:0] dbuf_shift_c;
   logic [AW-1:0] addr_c;
   logic [AW-1:0] addr_inc_c;
   logic          mem_we_c;
   logic          mem_re_c;
   logic [DW-1:0] mem_rdata;

   // Address nibbles enter at the bottom (MSB-first load); data nibbles enter at the top (LSB-first load).
   if (AB == NW) begin : g_abuf_one
      assign abuf_shift_c = nib;
   end else begin : g_abuf_multi
      assign abuf_shift_c = {abuf_q[AB-NW-1:0], nib};
   end

   if (DW == NW) begin : g_dbuf_one
      assign dbuf_shift_c = nib;
   end else begin : g_dbuf_multi
      assign dbuf_shift_c = {nib, dbuf_q[DW-1:NW]};
   end

   assign addr_c     = abuf_q[AW-1:0];
   assign addr_inc_c = addr_c + AW'(1);

   // Command decode; one command per cycle, so no read/write hazard exists.
   always_comb begin
      abuf_d     = abuf_q;
      dbuf_d     = dbuf_q;
      nib_cnt_d  = nib_cnt_q;
      rd_valid_d = 1'b0;
      wr_done_d  = 1'b0;
      mem_we_c   = 1'b0;
      mem_re_c   = 1'b0;
      if (cmd_valid) begin
         case (cmd_e'(cmd))
            CMD_SET_ADDR: begin
               abuf_d = abuf_shift_c;
            end
            CMD_WRITE_NIB: begin
               dbuf_d = dbuf_shift_c;
               if (nib_cnt_q == CW'(NPW - 1)) begin
                  // Last nibble of the word: commit and advance, dropping any upper abuf bits.
                  mem_we_c  = 1'b1;
                  nib_cnt_d = '0;
                  abuf_d    = AB'(addr_inc_c);
                  wr_done_d = 1'b1;
               end else begin
                  nib_cnt_d = nib_cnt_q + CW'(1);
               end
            end
            CMD_READ: begin
               mem_re_c   = 1'b1;
               rd_valid_d = 1'b1;
               abuf_d     = AB'(addr_inc_c);
            end
            CMD_CLEAR: begin
               nib_cnt_d = '0;
               dbuf_d    = '0;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         abuf_q     <= '0;
         dbuf_q     <= '0;
         nib_cnt_q  <= '0;
         rd_valid_q <= 1'b0;
         wr_done_q  <= 1'b0;
      end else begin
         abuf_q     <= abuf_d;
         dbuf_q     <= dbuf_d;
         nib_cnt_q  <= nib_cnt_d;
         rd_valid_q <= rd_valid_d;
         wr_done_q  <= wr_done_d;
      end
   end

   nibble_sram_mem #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we_c),
      .waddr (addr_c),
      .wdata (dbuf_shift_c),
      .re    (mem_re_c),
      .raddr (addr_c),
      .rdata (mem_rdata)
   );

   assign dout     = oe ? mem_rdata : '0;
   assign rd_valid = rd_valid_q;
   assign wr_done  = wr_done_q;
   assign nib_cnt  = nib_cnt_q;

endmodule
